// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg -- shared definitions for the multi-byte ALU sequencer.
//   SEL_* : 8-bit ALU select codes, also used as the wide-operation OP codes
//   state_t : sequencer FSM states
//   op_supported / op_desc / op_norec / op_rot : per-OP classification helpers
// Optional macro: ALU_SEQ_ROT_EN enables the ROL/ROR wide operations.
package alu_seq_pkg;

  localparam logic [3:0] SEL_ADD  = 4'd0;
  localparam logic [3:0] SEL_ADDC = 4'd1;
  localparam logic [3:0] SEL_SUB  = 4'd2;
  localparam logic [3:0] SEL_SUBC = 4'd3;
  localparam logic [3:0] SEL_CMP  = 4'd4;
  localparam logic [3:0] SEL_AND  = 4'd5;
  localparam logic [3:0] SEL_OR   = 4'd6;
  localparam logic [3:0] SEL_EXOR = 4'd7;
  localparam logic [3:0] SEL_TEST = 4'd8;
  localparam logic [3:0] SEL_LSL  = 4'd9;
  localparam logic [3:0] SEL_LSR  = 4'd10;
  localparam logic [3:0] SEL_ROL  = 4'd11;
  localparam logic [3:0] SEL_ROR  = 4'd12;
  localparam logic [3:0] SEL_ASR  = 4'd13;
  localparam logic [3:0] SEL_MOV  = 4'd14;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  function automatic logic op_supported(input logic [3:0] op);
    logic ok;
    case (op)
      4'd15: ok = 1'b0;
`ifdef ALU_SEQ_ROT_EN
      SEL_ROL, SEL_ROR: ok = 1'b1;
`else
      SEL_ROL, SEL_ROR: ok = 1'b0;
`endif
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Right shifts walk the bytes from the top down so the carry moves toward LSB.
  function automatic logic op_desc(input logic [3:0] op);
    return (op == SEL_LSR) || (op == SEL_ROR) || (op == SEL_ASR);
  endfunction

  // Flag-only operations: RES keeps its previous value.
  function automatic logic op_norec(input logic [3:0] op);
    return (op == SEL_CMP) || (op == SEL_TEST);
  endfunction

  function automatic logic op_rot(input logic [3:0] op);
    return (op == SEL_ROL) || (op == SEL_ROR);
  endfunction

endpackage

// File: rtl/alu_mb_seq_if.sv
// alu_mb_seq_if -- byte-wide port bundle of the shared 8-bit ALU.
//   a, b, sel, cin : operands/select/carry-in driven by the sequencer
//   result, c, z   : combinational ALU outputs
//   master : sequencer side, slave : ALU side
interface alu_mb_seq_if;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] sel;
  logic       cin;
  logic [7:0] result;
  logic       c;
  logic       z;

  modport master (output a, b, sel, cin, input result, c, z);
  modport slave  (input a, b, sel, cin, output result, c, z);
endinterface

// File: rtl/alu_seq_opmap.sv
// alu_seq_opmap -- maps a wide OP to the per-byte ALU select and carry-in.
//   op         : latched wide operation code
//   first_step : high for the first byte step of the operation
//   creg       : carry/borrow captured from the previous byte step
//   cin        : latched carry-in from the request
//   sel, alu_cin : byte-step ALU select / carry-in
//   desc       : bytes are processed from the top byte down
module alu_seq_opmap
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  input  logic       first_step,
  input  logic       creg,
  input  logic       cin,
  output logic [3:0] sel,
  output logic       alu_cin,
  output logic       desc
);

  always_comb begin
    sel     = op;
    alu_cin = 1'b0;
    desc    = op_desc(op);
    case (op)
      // ADD/SUB first step uses the no-carry form, later steps chain creg
      SEL_ADD: begin
        sel     = first_step ? SEL_ADD : SEL_ADDC;
        alu_cin = first_step ? 1'b0 : creg;
      end
      SEL_ADDC, SEL_SUBC, SEL_LSL, SEL_LSR: alu_cin = first_step ? cin : creg;
      SEL_SUB, SEL_CMP: begin
        sel     = first_step ? SEL_SUB : SEL_SUBC;
        alu_cin = first_step ? 1'b0 : creg;
      end
      SEL_TEST: sel = SEL_AND;
      // rotates run as plain shifts with a zero fill; the wrap bit is patched later
      SEL_ROL: begin
        sel     = SEL_LSL;
        alu_cin = first_step ? 1'b0 : creg;
      end
      SEL_ROR: begin
        sel     = SEL_LSR;
        alu_cin = first_step ? 1'b0 : creg;
      end
      // only the top byte needs sign replication; below it is a plain LSR
      SEL_ASR: begin
        sel     = first_step ? SEL_ASR : SEL_LSR;
        alu_cin = first_step ? 1'b0 : creg;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_mb_seq.sv
// alu_mb_seq -- multi-byte operation sequencer driving a shared 8-bit ALU.
//   clk, rst_n     : clock (rising edge), async active-low reset
//   start, op, cin : request; accepted only in IDLE
//   opa, opb       : 8*NBYTES-bit operands, latched on accept
//   busy, done, err: status (done/err are one-cycle pulses)
//   res, c_out, z_out : last completed result and flags
//   alu            : master side of the ALU port bundle
// Optional macro: ALU_SEQ_ROT_EN adds ROL/ROR via an extra FIX cycle.
module alu_mb_seq
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [3:0]              op,
  input  logic                    cin,
  input  logic [NBYTES-1:0][7:0]  opa,
  input  logic [NBYTES-1:0][7:0]  opb,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [NBYTES-1:0][7:0]  res,
  output logic                    c_out,
  output logic                    z_out,
  alu_mb_seq_if.master            alu
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  state_t                 state, state_nx;
  logic [NBYTES-1:0][7:0] a_q, b_q, work, fin_w;
  logic [3:0]             op_q;
  logic                   cin_q, creg, zacc, first;
  logic [IW-1:0]          idx;
  logic [3:0]             map_sel;
  logic                   map_cin, map_desc;
  logic                   accept, reject, last_byte;

  assign accept    = (state == S_IDLE) && start && op_supported(op);
  assign reject    = (state == S_IDLE) && start && !op_supported(op);
  assign last_byte = map_desc ? (idx == '0) : (idx == LAST);

  alu_seq_opmap u_opmap (
    .op        (op_q),
    .first_step(first),
    .creg      (creg),
    .cin       (cin_q),
    .sel       (map_sel),
    .alu_cin   (map_cin),
    .desc      (map_desc)
  );

  // ALU drive depends only on registered state, never on start
  always_comb begin
    alu.sel = '0;
    alu.cin = 1'b0;
    alu.a   = '0;
    alu.b   = '0;
    if (state == S_RUN) begin
      alu.sel = map_sel;
      alu.cin = map_cin;
      alu.a   = a_q[idx];
      alu.b   = b_q[idx];
    end
  end

  // work word with the byte currently on the ALU already merged in
  always_comb begin
    fin_w      = work;
    fin_w[idx] = alu.result;
  end

`ifdef ALU_SEQ_ROT_EN
  logic [NBYTES-1:0][7:0] fixed_w;

  // creg holds the bit shifted out of the far end; wrap it into the vacated bit
  always_comb begin
    fixed_w = work;
    if (op_q == SEL_ROL) fixed_w[0][0] = creg;
    else                 fixed_w[NBYTES-1][7] = creg;
  end
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = S_RUN;
      S_RUN: if (last_byte) begin
`ifdef ALU_SEQ_ROT_EN
        state_nx = op_rot(op_q) ? S_FIX : S_DONE;
`else
        state_nx = S_DONE;
`endif
      end
`ifdef ALU_SEQ_ROT_EN
      S_FIX:  state_nx = S_DONE;
`endif
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      work  <= '0;
      op_q  <= '0;
      cin_q <= 1'b0;
      creg  <= 1'b0;
      zacc  <= 1'b0;
      first <= 1'b0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      res   <= '0;
      c_out <= 1'b0;
      z_out <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != S_IDLE);
      done  <= 1'b0;
      err   <= reject;
      if (accept) begin
        a_q   <= opa;
        b_q   <= opb;
        op_q  <= op;
        cin_q <= cin;
        creg  <= 1'b0;
        zacc  <= 1'b1;
        first <= 1'b1;
        idx   <= op_desc(op) ? LAST : '0;
      end
      if (state == S_RUN) begin
        work  <= fin_w;
        creg  <= alu.c;
        zacc  <= zacc & alu.z;
        first <= 1'b0;
        idx   <= map_desc ? idx - IW'(1) : idx + IW'(1);
        // publish on the edge into DONE so res/flags are valid with the pulse
        if (last_byte && state_nx == S_DONE) begin
          done  <= 1'b1;
          if (!op_norec(op_q)) res <= fin_w;
          c_out <= alu.c;
          z_out <= zacc & alu.z;
        end
      end
`ifdef ALU_SEQ_ROT_EN
      if (state == S_FIX) begin
        done  <= 1'b1;
        res   <= fixed_w;
        c_out <= creg;
        z_out <= (fixed_w == '0);
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_mb_seq.sv
// tb_alu_mb_seq -- self-checking bench for alu_mb_seq (NBYTES=4) with a
// behavioural 8-bit ALU attached and a wide-word reference model.
module tb_alu_mb_seq;
  import alu_seq_pkg::*;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic          clk = 1'b0;
  logic          rst_n, start, cin, busy, done, err, c_out, z_out;
  logic [3:0]    op;
  logic [W-1:0]  opa, opb, res;

  int n_chk = 0;
  int n_fail = 0;

  logic [W-1:0] exp_res_q;
  logic         exp_c_q, exp_z_q;
  logic [3:0]   sel_seq [NB];

  alu_mb_seq_if alu_if ();

  alu_mb_seq #(.NBYTES(NB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .cin  (cin),
    .opa  (opa),
    .opb  (opb),
    .busy (busy),
    .done (done),
    .err  (err),
    .res  (res),
    .c_out(c_out),
    .z_out(z_out),
    .alu  (alu_if)
  );

  always #5 clk = ~clk;

  // 8-bit ALU: C is carry out for add, borrow for subtract, shifted-out bit for shifts
  always_comb begin
    logic [8:0] t;
    t = '0;
    case (alu_if.sel)
      4'd0:  t = {1'b0, alu_if.a} + {1'b0, alu_if.b};
      4'd1:  t = {1'b0, alu_if.a} + {1'b0, alu_if.b} + {8'd0, alu_if.cin};
      4'd2:  t = {1'b0, alu_if.a} - {1'b0, alu_if.b};
      4'd3:  t = {1'b0, alu_if.a} - {1'b0, alu_if.b} - {8'd0, alu_if.cin};
      4'd5:  t = {1'b0, alu_if.a & alu_if.b};
      4'd6:  t = {1'b0, alu_if.a | alu_if.b};
      4'd7:  t = {1'b0, alu_if.a ^ alu_if.b};
      4'd9:  t = {alu_if.a, alu_if.cin};
      4'd10: t = {alu_if.a[0], alu_if.cin, alu_if.a[7:1]};
      4'd13: t = {alu_if.a[0], alu_if.a[7], alu_if.a[7:1]};
      4'd14: t = {1'b0, alu_if.b};
      default: t = '0;
    endcase
    alu_if.result = t[7:0];
    alu_if.c      = t[8];
    alu_if.z      = (t[7:0] == 8'd0);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Whole-word reference: what the wide operation means, independent of byte stepping
  task automatic model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, output logic [W-1:0] r, output logic c,
                       output logic z, output bit bad);
    logic [W:0] t;
    t   = '0;
    bad = 1'b0;
    case (o)
      SEL_ADD:          t = {1'b0, a} + {1'b0, b};
      SEL_ADDC:         t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      SEL_SUB, SEL_CMP: t = {1'b0, a} - {1'b0, b};
      SEL_SUBC:         t = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, ci};
      SEL_AND, SEL_TEST: t = {1'b0, a & b};
      SEL_OR:           t = {1'b0, a | b};
      SEL_EXOR:         t = {1'b0, a ^ b};
      SEL_MOV:          t = {1'b0, b};
      SEL_LSL:          t = {a, ci};
      SEL_LSR:          t = {a[0], ci, a[W-1:1]};
      SEL_ASR:          t = {a[0], W'($signed(a) >>> 1)};
`ifdef ALU_SEQ_ROT_EN
      SEL_ROL:          t = {a[W-1], a[W-2:0], a[W-1]};
      SEL_ROR:          t = {a[0], a[0], a[W-1:1]};
`endif
      default:          bad = 1'b1;
    endcase
    r = t[W-1:0];
    c = t[W];
    z = (r == '0);
  endtask

  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input bit mid);
    logic [W-1:0] r;
    logic c, z;
    bit bad;
    int lat, bi;
    model(o, a, b, ci, r, c, z, bad);
    lat = NB + 1 + (((o == SEL_ROL) || (o == SEL_ROR)) ? 1 : 0);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b; cin = ci;
    if (bad) begin
      @(negedge clk);
      start = 1'b0;
      chk("err_pulse", 64'(err), 64'(1));
      chk("err_busy", 64'(busy), 64'(0));
      @(negedge clk);
      chk("err_clear", 64'(err), 64'(0));
      chk("err_done", 64'(done), 64'(0));
      chk("err_res_kept", 64'(res), 64'(exp_res_q));
      chk("err_flags_kept", 64'({c_out, z_out}), 64'({exp_c_q, exp_z_q}));
      return;
    end
    for (int j = 1; j <= lat; j++) begin
      @(negedge clk);
      if (j == 1) start = 1'b0;
      if (mid && j == 2) start = 1'b1;
      if (mid && j == 3) start = 1'b0;
      if (j <= NB) begin
        bi = op_desc(o) ? NB - j : j - 1;
        sel_seq[j-1] = alu_if.sel;
        chk("run_busy", 64'(busy), 64'(1));
        chk("run_byte", 64'(alu_if.a), 64'(a[bi*8 +: 8]));
      end
      if (j < lat) begin
        chk("early_done", 64'(done), 64'(0));
      end else begin
        if (!((o == SEL_CMP) || (o == SEL_TEST))) exp_res_q = r;
        exp_c_q = c;
        exp_z_q = z;
        chk("done_pulse", 64'(done), 64'(1));
        chk("done_busy", 64'(busy), 64'(1));
        chk("res", 64'(res), 64'(exp_res_q));
        chk("c_out", 64'(c_out), 64'(exp_c_q));
        chk("z_out", 64'(z_out), 64'(exp_z_q));
        chk("alu_sel_idle", 64'(alu_if.sel), 64'(0));
      end
    end
    @(negedge clk);
    chk("post_done", 64'(done), 64'(0));
    chk("post_busy", 64'(busy), 64'(0));
    if (mid) begin
      @(negedge clk);
      chk("mid_no_second_done", 64'({done, busy}), 64'(0));
    end
  endtask

  initial begin
    bit saw_done;
    rst_n = 1'b0; start = 1'b0; op = '0; cin = 1'b0; opa = '0; opb = '0;
    exp_res_q = '0; exp_c_q = 1'b0; exp_z_q = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_status", 64'({busy, done, err}), 64'(0));
    chk("rst_res", 64'(res), 64'(0));
    chk("rst_flags", 64'({c_out, z_out}), 64'(0));
    chk("rst_alu", 64'({alu_if.sel, alu_if.cin, alu_if.a, alu_if.b}), 64'(0));
    rst_n = 1'b1;

    run_op(SEL_ADD, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    chk("add_res", 64'(res), 64'(32'h0100_0000));
    chk("add_sel0", 64'(sel_seq[0]), 64'(0));
    chk("add_sel1", 64'(sel_seq[1]), 64'(1));
    chk("add_sel3", 64'(sel_seq[3]), 64'(1));
    run_op(SEL_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
    chk("sub_borrow", 64'({res, c_out}), 64'({32'hFFFF_FFFF, 1'b1}));
    run_op(SEL_CMP, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
    chk("cmp_keep", 64'({res, c_out, z_out}), 64'({32'hFFFF_FFFF, 1'b0, 1'b1}));
    run_op(SEL_LSR, 32'h8000_0001, 32'h0, 1'b0, 1'b0);
    chk("lsr", 64'({res, c_out}), 64'({32'h4000_0000, 1'b1}));
    run_op(SEL_ASR, 32'h8000_0000, 32'h0, 1'b0, 1'b0);
    chk("asr", 64'({res, c_out}), 64'({32'hC000_0000, 1'b0}));
    run_op(SEL_ROL, 32'h8000_0001, 32'h0, 1'b0, 1'b0);
    run_op(SEL_ROR, 32'h8000_0001, 32'h0, 1'b1, 1'b0);
    run_op(4'd15, 32'h1, 32'h1, 1'b0, 1'b0);
    run_op(SEL_ADDC, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);

    // reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; op = SEL_ADD; opa = 32'h1111_1111; opb = 32'h2222_2222;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_res", 64'(res), 64'(0));
    chk("midrst_alu", 64'(alu_if.sel), 64'(0));
    saw_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done || err) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || err) saw_done = 1'b1;
    end
    chk("midrst_no_done", 64'(saw_done), 64'(0));
    exp_res_q = '0; exp_c_q = 1'b0; exp_z_q = 1'b0;

    run_op(SEL_ADD, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
    run_op(SEL_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, 1'b0);
    chk("and_zero", 64'({res, c_out, z_out}), 64'({32'h0, 1'b0, 1'b1}));
    run_op(SEL_MOV, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0);
    chk("mov_z", 64'(z_out), 64'(1));

    for (int n = 0; n < 80; n++) begin
      logic [3:0] o;
      logic [W-1:0] a, b;
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      run_op(o, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mb_seq.md
# alu_mb_seq

Multi-byte operation sequencer for the 8-bit ALU. It accepts one 8·NBYTES-bit operation and drives the shared ALU one byte per cycle, chaining carry/borrow between bytes. It accumulates the Z flag across bytes and returns a wide result with final C/Z. It sits between the control unit and the ALU instance, and owns the ALU's SEL/CIN/A/B inputs while BUSY.

## Interface
- NBYTES, 4: operand width in bytes, 2..8
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  request; accepted only in IDLE
- OP  in  4  ALU SEL code of requested operation
- CIN  in  1  carry-in for the first byte step
- OPA, OPB  in  8·NBYTES  operands, latched on accept
- BUSY  out  1  high in RUN/FIX/DONE
- DONE  out  1  one-cycle pulse; RES/C_OUT/Z_OUT valid
- ERR  out  1  one-cycle pulse; unsupported OP rejected
- RES  out  8·NBYTES  last completed result
- C_OUT, Z_OUT  out  1  last completed flags
- ALU_A, ALU_B  out  8  current byte operands
- ALU_SEL  out  4  current byte SEL
- ALU_CIN  out  1  current byte carry-in
- ALU_RESULT  in  8  ALU output
- ALU_C, ALU_Z  in  1  ALU flags

## Operation
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE → RUN on START with a supported OP. Latch OPA, OPB, OP and CIN. Load the byte index to 0, or to NBYTES-1 for right-shift ops. Set zacc=1.
- IDLE with START and an unsupported OP: pulse ERR for the next cycle, remain IDLE, leave RES and flags untouched.
- RUN, each cycle:
  - Present byte i on ALU_A/ALU_B.
  - Capture ALU_RESULT into work byte i and ALU_C into creg.
  - Update zacc &= ALU_Z.
  - Step i.
- Byte mapping (first step / subsequent steps):
  - ADD: SEL 0 / 1, CIN=creg.
  - ADDC: SEL 1 with CIN port / 1, CIN=creg.
  - SUB: SEL 2 / 3.
  - SUBC: SEL 3 with CIN port / 3.
  - CMP: as SUB; RES is not updated.
  - AND/OR/EXOR/MOV: own SEL at every step, bytes ascending.
  - TEST: as AND; RES is not updated.
  - LSL: SEL 9 ascending, CIN port first, then creg.
  - LSR: SEL 10 descending, CIN port first, then creg.
  - ASR: SEL 13 on the top byte, then SEL 10 with creg, descending.
- After the last byte: go to FIX for ROL/ROR (macro builds only), otherwise to DONE.
- DONE (one cycle):
  - DONE=1.
  - RES ← work, except for CMP/TEST.
  - C_OUT ← creg, Z_OUT ← zacc.
  - Next state IDLE.
- START while BUSY: ignored, no queuing.
- ALU_SEL/ALU_CIN/ALU_A/ALU_B are 0 outside RUN.
- RST_N low at any time, including mid-operation: immediate return to IDLE; all outputs and registers 0; no DONE or ERR.

## Timing
- START sampled at edge k:
  - RUN during cycles k+1 … k+NBYTES.
  - DONE high during cycle k+NBYTES+1 (or k+NBYTES+2 with FIX).
  - IDLE at the following edge.
- A new START is accepted in the first IDLE cycle after DONE.
- ERR is high during cycle k+1; BUSY stays 0.
- DONE, ERR, BUSY and RES are registered. ALU_* outputs decode from the state/index registers only, with no START combinational path.
- The ALU is combinational; each byte closes within one CLK period.

## Configuration
- ALU_SEQ_ROT_EN defined:
  - ROL (11) runs as LSL with first CIN=0. FIX then sets RES bit 0 ← creg (original MSB); C_OUT = creg.
  - ROR (12) runs as LSR with first CIN=0. FIX then sets top bit ← creg (original LSB).
  - Z_OUT is recomputed in FIX over the fixed word.
- ALU_SEQ_ROT_EN undefined: OP 11, 12 and 15 raise ERR. The FIX state is absent.
- With the macro defined, OP 15 still raises ERR.

## Structure
- Package alu_seq_pkg:
  - SEL code localparams 0–14 (ADD … MOV).
  - State enum.
  - Function op_supported().
- Sub-module alu_seq_opmap: combinational map (op, first_step, creg, cin) → (ALU_SEL, ALU_CIN, descending).
- The ALU instance is external; this block only drives its ports.

## Test plan
- NBYTES=4, ADD 0x00FF_FFFF + 0x0000_0001 → RES=0x0100_0000, C=0, Z=0. DONE in cycle k+5; ALU_SEL sequence 0,1,1,1.
- SUB 0x0000_0000 − 0x0000_0001 → RES=0xFFFF_FFFF, C=1. Then CMP 0x1234_5678 vs 0x1234_5678 → Z=1, C=0, RES still 0xFFFF_FFFF.
- LSR 0x8000_0001 with CIN=0 → RES=0x4000_0000, C=1; bytes processed 3,2,1,0. ASR 0x8000_0000 → RES=0xC000_0000, C=0.
- ROL 0x8000_0001, macro defined → RES=0x0000_0003, C=1, DONE at k+6. Same OP with macro undefined → ERR pulse only.
- START pulsed at the RUN cycle k+2 → ignored, single DONE. RST_N low at cycle k+3 → BUSY=0, RES=0, no DONE. A fresh ADD afterwards completes normally.
- AND 0xF0F0_F0F0 & 0x0F0F_0F0F → RES=0, Z=1, C=0. MOV OPB=0x0000_0000 → Z=1.
